// File: rtl/fetch_defs_pkg.sv
// Shared definitions for the instruction fetch stage: default geometry,
// FSM state encoding and prefetch queue depth.
package fetch_defs;

  localparam int unsigned ADDR_W_DEF      = 8;
  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam logic [7:0]  RESET_PC_DEF    = 8'h00;
  localparam int unsigned FIFO_DEPTH      = 2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } fetch_state_e;

  // Queue entry layout at default widths: {pc, byte}.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry prefetch queue of {pc, byte}; the head is held in a register so
// IR/IR_PC are registered outputs. Flush drops all entries in one edge.
module fetch_fifo
  import fetch_defs::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_data
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  entry_t     ent0_r;
  entry_t     ent1_r;
  entry_t     in_s;
  logic [1:0] count_r;
  logic       valid_r;
  logic       pop_s;

  assign in_s  = '{pc: push_pc, data: push_data};
  assign pop_s = pop & valid_r;

  // Queue storage: entry 0 is always the head, pops shift entry 1 forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_r  <= '0;
      ent1_r  <= '0;
      count_r <= 2'd0;
      valid_r <= 1'b0;
    end else if (flush) begin
      count_r <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      case ({push, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            ent0_r <= in_s;
          end else begin
            ent1_r <= in_s;
          end
          count_r <= count_r + 2'd1;
          valid_r <= 1'b1;
        end
        2'b01: begin
          ent0_r  <= ent1_r;
          count_r <= count_r - 2'd1;
          valid_r <= (count_r == FULL);
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            ent0_r <= in_s;
          end else begin
            ent0_r <= ent1_r;
            ent1_r <= in_s;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign count      = count_r;
  assign head_valid = valid_r;
  assign head_pc    = ent0_r.pc;
  assign head_data  = ent0_r.data;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, runs fixed wait-state reads against
// the instruction memory and feeds decode through a 2-entry prefetch queue.
module instr_fetch
  import fetch_defs::*;
#(
  parameter int unsigned       ADDR_W      = ADDR_W_DEF,
  parameter int unsigned       DATA_W      = DATA_W_DEF,
  parameter int unsigned       WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = RESET_PC_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              CSB,
  output logic              WRB,
  output logic [ADDR_W-1:0] ABUS,
  input  logic [DATA_W-1:0] DATABUS,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] IR_PC,
  output logic              IR_VALID,
  input  logic              IR_READY,
  input  logic              BR_TAKEN,
  input  logic [ADDR_W-1:0] BR_TARGET
);

  localparam int unsigned      CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  fetch_state_e      state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [ADDR_W-1:0] fetch_pc_r, fetch_pc_s;
  logic [ADDR_W-1:0] abus_r, abus_s;
  logic              csb_r, csb_s;
  logic              wrb_r;
  logic              push_s, flush_s, pop_s;
  logic [1:0]        count_s, occ_pop_s;
  logic [ADDR_W-1:0] pc_inc_s;

  assign pop_s     = IR_VALID & IR_READY;
  assign occ_pop_s = count_s - {1'b0, pop_s};
  assign pc_inc_s  = fetch_pc_r + ADDR_W'(1);

  // State, counter, PC and memory-side output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      fetch_pc_r <= RESET_PC;
      abus_r     <= RESET_PC;
      csb_r      <= 1'b1;
      wrb_r      <= 1'b1;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      fetch_pc_r <= fetch_pc_s;
      abus_r     <= abus_s;
      csb_r      <= csb_s;
      wrb_r      <= 1'b1;
    end
  end

  // Next-state logic. An access only starts when a queue slot is free after
  // this edge's pop, so the sample-edge push can never find the queue full.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    fetch_pc_s = fetch_pc_r;
    abus_s     = abus_r;
    csb_s      = csb_r;
    push_s     = 1'b0;
    flush_s    = 1'b0;
    if (BR_TAKEN) begin
      // fetch_pc follows the target; the sample edge advances it to target+1.
      flush_s    = 1'b1;
      state_s    = ACCESS;
      abus_s     = BR_TARGET;
      csb_s      = 1'b0;
      cnt_s      = '0;
      fetch_pc_s = BR_TARGET;
    end else begin
      case (state_r)
        IDLE: begin
          if (occ_pop_s != 2'(FIFO_DEPTH)) begin
            state_s = ACCESS;
            abus_s  = fetch_pc_r;
            csb_s   = 1'b0;
            cnt_s   = '0;
          end else begin
            state_s = IDLE;
          end
        end
        ACCESS: begin
          if (cnt_r == CNT_LAST) begin
            push_s     = 1'b1;
            fetch_pc_s = pc_inc_s;
            cnt_s      = '0;
            if (occ_pop_s == 2'd0) begin
              abus_s = pc_inc_s;
            end else begin
              state_s = IDLE;
              csb_s   = 1'b1;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = IDLE;
          csb_s   = 1'b1;
          cnt_s   = '0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (CLK),
    .rst        (RST),
    .flush      (flush_s),
    .push       (push_s),
    .push_pc    (fetch_pc_r),
    .push_data  (DATABUS),
    .pop        (pop_s),
    .count      (count_s),
    .head_valid (IR_VALID),
    .head_pc    (IR_PC),
    .head_data  (IR)
  );

  assign CSB  = csb_r;
  assign WRB  = wrb_r;
  assign ABUS = abus_r;

endmodule
